prog_counter_stack: RTL
=======================

// Module: prog_counter_stack
// PURPOSE
//   Parametrised program counter with opcode-driven next-address selection: increment,
//   decrement, absolute jump, signed relative branch, and call/return via an internal
//   LIFO return-address stack. Drives the address bus through an output-enable pair for
//   external tristate. Successor to the 8-bit loadable counter. Sits between the
//   instruction decoder and the shared address bus.
// PARAMETERS
//   WIDTH   8   counter, operand and stack-entry width in bits (>=2)
//   DEPTH   4   return-stack entries (>=1); SPW = $clog2(DEPTH+1)
// PORTS
//   clk          in   1      rising-edge clock
//   rst          in   1      synchronous active-high reset
//   en           in   1      execute op this cycle; 0 = hold everything
//   op           in   3      operation code (see BEHAVIOUR)
//   operand      in   WIDTH  jump target (LOAD/CALL) or two's-complement offset (BRANCH)
//   out_en       in   1      bus output request
//   err_clr      in   1      clears sticky err
//   count        out  WIDTH  current program counter (registered)
//   bus_out      out  WIDTH  count when out_en=1, else 0
//   bus_oe       out  1      = out_en; top level builds tristate: bus = bus_oe ? bus_out : 'z
//   sp           out  SPW    stack occupancy, 0..DEPTH
//   stack_full   out  1      sp == DEPTH
//   stack_empty  out  1      sp == 0
//   err          out  1      sticky: CALL on full or RET on empty
// BEHAVIOUR
//   - Reset (rst=1 at edge, highest priority, any op/en): count=0, sp=0, err=0, stack=0.
//   - All state updates on the rising clk edge; count, sp, err registered; 1-cycle latency.
//   - bus_out, bus_oe, stack_full, stack_empty are combinational from registers/out_en.
//   - en=0: count, sp, stack hold; err still honours err_clr.
//   - op codes (en=1):
//       000 HOLD    no change
//       001 INC     count <= count + 1
//       010 LOAD    count <= operand
//       011 BRANCH  count <= count + sign-extended operand
//       100 CALL    if !full: stack[sp] <= count + 1, sp <= sp + 1, count <= operand
//                   if full: no push, count holds, err <= 1
//       101 RET     if !empty: count <= stack[sp-1], sp <= sp - 1
//                   if empty: count holds, err <= 1
//       110 DEC     count <= count - 1
//       111 FLUSH   sp <= 0 (stack discarded), count unchanged
//   - Arithmetic modulo 2^WIDTH: INC at all-ones -> 0; DEC at 0 -> all-ones; BRANCH wraps
//     both directions; CALL return address count+1 wraps to 0.
//   - err: set on failed CALL/RET; cleared by err_clr; if set and clear occur in the same
//     cycle, set wins. Failed ops never modify stack or sp.
//   - Stack entries above sp are don't-care; only stack[sp-1] is observable (via RET).
//   - rst asserted mid-sequence (e.g. between CALL and RET) loses all return addresses.
// TESTING
//   1. rst=1 with en=1, op=INC -> count=0, sp=0, err=0, stack_empty=1 after the edge.
//   2. WIDTH=8: LOAD 0xFE, INC, INC -> count 0xFE, 0xFF, 0x00; DEC -> 0xFF.
//   3. count=0x10: BRANCH 0xFC -> 0x0C; BRANCH 0x7F -> 0x8B; count=0xF0, BRANCH 0x20 -> 0x10.
//   4. DEPTH=4, count=0x20: CALL 0x40, 0x50, 0x60, 0x70 -> sp=4, full=1; 5th CALL 0x80
//      -> count stays 0x70, err=1, sp=4; RET x4 -> 0x61, 0x51, 0x41, 0x21, empty=1.
//   5. sp=0: RET -> count holds, err=1; err_clr with a second failing RET same cycle
//      -> err stays 1; err_clr alone -> err=0; FLUSH with sp=3 -> sp=0, count unchanged.
//   6. count=0x33: out_en=1 -> bus_out=0x33, bus_oe=1 same cycle; out_en=0 -> bus_out=0,
//      bus_oe=0; en=0 with op=INC -> count holds 0x33.

Source files
------------

// File: rtl/prog_counter_stack_if.sv
// Decoder-side bundle for the program counter: op request in, count/stack status out.
// The master drives the op request; the slave is the counter.
interface prog_counter_stack_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) ();
    localparam int SPW = $clog2(DEPTH + 1);

    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand;
    logic             out_en;
    logic             err_clr;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] bus_out;
    logic             bus_oe;
    logic [SPW-1:0]   sp;
    logic             stack_full;
    logic             stack_empty;
    logic             err;

    modport master (
        output en, op, operand, out_en, err_clr,
        input  count, bus_out, bus_oe, sp, stack_full, stack_empty, err
    );

    modport slave (
        input  en, op, operand, out_en, err_clr,
        output count, bus_out, bus_oe, sp, stack_full, stack_empty, err
    );
endinterface

// File: rtl/prog_counter_stack.sv
// Program counter with inc/dec/jump/relative branch and a LIFO return stack
// for call/return; drives the shared address bus through an output enable.
module prog_counter_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input logic                  clk,
    input logic                  rst,
    prog_counter_stack_if.slave  pc
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int SLOTS = 2 ** SPW;

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_INC    = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_BRANCH = 3'b011;
    localparam logic [2:0] OP_CALL   = 3'b100;
    localparam logic [2:0] OP_RET    = 3'b101;
    localparam logic [2:0] OP_DEC    = 3'b110;
    localparam logic [2:0] OP_FLUSH  = 3'b111;

    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [SPW-1:0]   SP_ONE = SPW'(1);
    localparam logic [SPW-1:0]   SP_MAX = SPW'(DEPTH);

    logic [WIDTH-1:0] count_q, count_d;
    logic [SPW-1:0]   sp_q, sp_d, sp_dec;
    logic             err_q, err_d;
    logic             push;
    logic             full, empty;

    // Sized to the full sp range so sp indexes it directly; slots >= DEPTH stay unused.
    logic [WIDTH-1:0] stack_q [SLOTS];

    assign full   = (sp_q == SP_MAX);
    assign empty  = (sp_q == '0);
    assign sp_dec = sp_q - SP_ONE;

    always_comb begin
        count_d = count_q;
        sp_d    = sp_q;
        err_d   = err_q & ~pc.err_clr;
        push    = 1'b0;
        if (pc.en) begin
            unique case (pc.op)
                OP_HOLD:   count_d = count_q;
                OP_INC:    count_d = count_q + ONE;
                OP_LOAD:   count_d = pc.operand;
                // Same-width add wraps exactly like a sign-extended offset.
                OP_BRANCH: count_d = count_q + pc.operand;
                OP_CALL: begin
                    if (!full) begin
                        push    = 1'b1;
                        sp_d    = sp_q + SP_ONE;
                        count_d = pc.operand;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!empty) begin
                        count_d = stack_q[sp_dec];
                        sp_d    = sp_dec;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_DEC:    count_d = count_q - ONE;
                OP_FLUSH:  sp_d = '0;
                default:   count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
            if (push) begin
                stack_q[sp_q] <= count_q + ONE;
            end
        end
    end

    assign pc.count       = count_q;
    assign pc.bus_out     = pc.out_en ? count_q : '0;
    assign pc.bus_oe      = pc.out_en;
    assign pc.sp          = sp_q;
    assign pc.stack_full  = full;
    assign pc.stack_empty = empty;
    assign pc.err         = err_q;
endmodule
